// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry holding slot per functional unit, round-robin grant of one
// occupied slot per cycle onto a registered common data bus.
module cdb_arbiter #(
   parameter int NUM_FU    = 5,
   parameter int DATA_W    = 32,
   parameter int ROB_IDX_W = 3
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        flush_in,
   input  logic [NUM_FU-1:0]           fu_valid_in,
   input  logic [NUM_FU*DATA_W-1:0]    fu_data_in,
   input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx_in,
   output logic [NUM_FU-1:0]           fu_ready_out,
   output logic                        cdb_valid_out,
   output logic [DATA_W-1:0]           cdb_data_out,
   output logic [ROB_IDX_W-1:0]        cdb_rob_idx_out,
   output logic [2:0]                  cdb_fu_id_out,
   output logic                        overflow_out
);
   logic [NUM_FU-1:0]    occ_q, occ_d, grant;
   logic [DATA_W-1:0]    data_q [NUM_FU];
   logic [DATA_W-1:0]    data_d [NUM_FU];
   logic [ROB_IDX_W-1:0] rob_q [NUM_FU];
   logic [ROB_IDX_W-1:0] rob_d [NUM_FU];
   logic [2:0]           rr_q, rr_d, gnt_id, fu_id_q, fu_id_d;
   logic [3:0]           idx;
   logic                 found, ovf_q, ovf_d, valid_q, valid_d;
   logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
   logic [ROB_IDX_W-1:0] cdb_rob_q, cdb_rob_d;

   // Rotating search starting at rr; the first occupied slot wins.
   always_comb begin
      idx    = '0;
      gnt_id = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = {1'b0, rr_q} + 4'(k);
         idx = (idx >= 4'(NUM_FU)) ? idx - 4'(NUM_FU) : idx;
         if (!found && occ_q[idx[2:0]]) begin
            found  = 1'b1;
            gnt_id = idx[2:0];
         end
      end
      grant = {{(NUM_FU-1){1'b0}}, found} << gnt_id;
   end

   assign fu_ready_out = ~occ_q | grant | {NUM_FU{flush_in}};

   // A new capture overrides the same-edge clear of a granted slot.
   always_comb begin
      occ_d  = occ_q & ~grant;
      data_d = data_q;
      rob_d  = rob_q;
      ovf_d  = ovf_q;
      for (int i = 0; i < NUM_FU; i++) begin
         if (fu_valid_in[i] && fu_ready_out[i]) begin
            occ_d[i]  = 1'b1;
            data_d[i] = fu_data_in[i*DATA_W +: DATA_W];
            rob_d[i]  = fu_rob_idx_in[i*ROB_IDX_W +: ROB_IDX_W];
         end else if (fu_valid_in[i]) begin
            ovf_d = 1'b1;
         end
      end
      if (flush_in) occ_d = '0;
   end

   assign valid_d    = found & ~flush_in;
   assign cdb_data_d = valid_d ? data_q[gnt_id] : cdb_data_q;
   assign cdb_rob_d  = valid_d ? rob_q[gnt_id] : cdb_rob_q;
   assign fu_id_d    = valid_d ? gnt_id : fu_id_q;
   assign rr_d       = !valid_d ? rr_q : (gnt_id == 3'(NUM_FU-1)) ? 3'd0 : gnt_id + 3'd1;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         occ_q      <= '0;
         data_q     <= '{default: '0};
         rob_q      <= '{default: '0};
         rr_q       <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
         cdb_data_q <= '0;
         cdb_rob_q  <= '0;
         fu_id_q    <= '0;
      end else begin
         occ_q      <= occ_d;
         data_q     <= data_d;
         rob_q      <= rob_d;
         rr_q       <= rr_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         cdb_data_q <= cdb_data_d;
         cdb_rob_q  <= cdb_rob_d;
         fu_id_q    <= fu_id_d;
      end
   end

   assign cdb_valid_out   = valid_q;
   assign cdb_data_out    = cdb_data_q;
   assign cdb_rob_idx_out = cdb_rob_q;
   assign cdb_fu_id_out   = fu_id_q;
   assign overflow_out    = ovf_q;
endmodule
